// File: rtl/lifo_pkg.sv
// ----------------------------------------------------------------------------
// lifo_pkg
//  Shared types and helpers for the multi-channel LIFO (lifo_multi).
//  Contents:
//    lifo_op_e    - operation actually applied to the selected channel
//    lifo_decode  - maps push/pop/flush plus the channel's empty/full state
//                   onto one lifo_op_e value
// ----------------------------------------------------------------------------
package lifo_pkg;

  typedef enum logic [2:0] {
    OP_NONE,   // nothing changes (idle, or a dropped push / ignored pop)
    OP_PUSH,   // write at count, count+1
    OP_POP,    // read top, count-1
    OP_SWAP,   // read old top and overwrite it with data_in, count held
    OP_PASS,   // push&pop on an empty stack: data_in goes straight out
    OP_FLUSH   // count to zero
  } lifo_op_e;

  // Flush dominates. A push on a full stack and a pop on an empty stack
  // decode to OP_NONE; the error flags are raised separately from the raw
  // request bits, so the decoded op only ever describes real state changes.
  function automatic lifo_op_e lifo_decode(
    input logic push,
    input logic pop,
    input logic flush,
    input logic empty,
    input logic full
  );
    lifo_op_e op;
    op = OP_NONE;
    if (flush) begin
      op = OP_FLUSH;
    end else if (push && pop) begin
      op = empty ? OP_PASS : OP_SWAP;
    end else if (push) begin
      op = full ? OP_NONE : OP_PUSH;
    end else if (pop) begin
      op = empty ? OP_NONE : OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/lifo_ch_ctrl.sv
// ----------------------------------------------------------------------------
// lifo_ch_ctrl
//  Per-channel bookkeeping for lifo_multi: occupancy counter, empty/full
//  status and the sticky overflow/underflow flags. Storage lives in the top.
//  Optional feature macro: LIFO_ERR_FLAGS_EN (sticky error flags). Without
//  it overflow/underflow are constant 0 and err_clr is ignored.
// Ports:
//  clk, rst   clock (rising edge), asynchronous active-high reset
//  sel        this channel is addressed this cycle
//  op         decoded operation for the addressed channel
//  push, pop  raw requests, used only to detect error events
//  err_clr    clear both error flags
//  count      current occupancy 0..DEPTH
//  empty/full count==0 / count==DEPTH
//  overflow   sticky: push dropped because the stack was full
//  underflow  sticky: pop requested on an empty stack
// ----------------------------------------------------------------------------
import lifo_pkg::*;

module lifo_ch_ctrl #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  lifo_op_e         op,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (sel) begin
      case (op)
        OP_FLUSH: cnt_reg <= '0;
        OP_PUSH:  cnt_reg <= cnt_reg + CNT_W'(1);
        OP_POP:   cnt_reg <= cnt_reg - CNT_W'(1);
        default:  cnt_reg <= cnt_reg;  // swap, pass-through, none
      endcase
    end
  end

  assign count = cnt_reg;
  assign empty = (cnt_reg == '0);
  assign full  = (cnt_reg == CNT_W'(DEPTH));

`ifdef LIFO_ERR_FLAGS_EN
  logic overflow_reg;
  logic underflow_reg;
  logic ovf_evt;
  logic unf_evt;

  // A lone push that decoded to OP_NONE can only mean "full"; a lone pop that
  // decoded to OP_NONE can only mean "empty". Flush decodes to OP_FLUSH, so
  // it never raises a flag.
  assign ovf_evt = sel && (op == OP_NONE) && push && !pop;
  assign unf_evt = sel && (op == OP_NONE) && pop && !push;

  // The event assignment comes after the clear so a same-cycle error wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (err_clr) begin
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end
      if (ovf_evt) overflow_reg  <= 1'b1;
      if (unf_evt) underflow_reg <= 1'b1;
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`else
  // Flags disabled: ports stay, inputs that only feed the flags are sunk here.
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{push, pop, err_clr};
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: rtl/lifo_multi.sv
// ----------------------------------------------------------------------------
// lifo_multi
//  NUM_CH independent LIFO stacks of DEPTH x WIDTH sharing one storage array.
//  One operation per cycle on ch_sel: push, pop, push&pop (swap when the stack
//  holds data, pass-through when empty) or flush (highest priority).
//  Storage address = {ch, ptr} == ch*DEPTH + ptr; one write and one registered
//  read per cycle so the array maps onto block RAM.
//  Optional feature macro: LIFO_ERR_FLAGS_EN (sticky overflow/underflow).
// Ports:
//  clk, rst   clock (rising edge), asynchronous active-high reset
//  ch_sel     channel addressed this cycle (>= NUM_CH: operation ignored)
//  push/pop/flush, data_in   operation request and push data
//  data_out   popped word, registered, valid with out_valid
//  out_valid  one-cycle pulse when data_out was updated
//  count      per-channel occupancy, channel k at [k*CNT_W +: CNT_W]
//  empty/full per-channel status
//  err_clr    clear all error flags
//  overflow/underflow  per-channel sticky error flags
// ----------------------------------------------------------------------------
import lifo_pkg::*;

module lifo_multi #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        data_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    out_valid,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       full,
  input  logic                    err_clr,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       underflow
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int ADDR_W   = CH_W + PTR_W;
  localparam int MEM_SIZE = NUM_CH * DEPTH;

  // --------------------------------------------------------------------------
  // Per-channel controllers
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_arr [NUM_CH];
  logic             ch_valid;
  lifo_op_e         op;

  // Widen by one bit so the compare also works when NUM_CH is a power of two.
  assign ch_valid = ({1'b0, ch_sel} < (CH_W + 1)'(NUM_CH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic ch_hit;
      assign ch_hit = ch_valid && (ch_sel == CH_W'(gi));

      lifo_ch_ctrl #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
      ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .sel       (ch_hit),
        .op        (op),
        .push      (push),
        .pop       (pop),
        .err_clr   (err_clr),
        .count     (cnt_arr[gi]),
        .empty     (empty[gi]),
        .full      (full[gi]),
        .overflow  (overflow[gi]),
        .underflow (underflow[gi])
      );

      assign count[gi*CNT_W +: CNT_W] = cnt_arr[gi];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Status of the addressed channel and operation decode
  // --------------------------------------------------------------------------
  logic             sel_empty;
  logic             sel_full;
  logic [PTR_W-1:0] sel_ptr;

  // The low PTR_W count bits are the next free slot; when the stack is full
  // they wrap to 0, which still yields the right top pointer (DEPTH-1) below.
  always_comb begin
    sel_empty = 1'b0;
    sel_full  = 1'b0;
    sel_ptr   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel == CH_W'(k)) begin
        sel_empty = empty[k];
        sel_full  = full[k];
        sel_ptr   = cnt_arr[k][PTR_W-1:0];
      end
    end
  end

  assign op = ch_valid ? lifo_decode(push, pop, flush, sel_empty, sel_full)
                       : OP_NONE;

  // --------------------------------------------------------------------------
  // Shared storage: one write port, one registered read port
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  mem [MEM_SIZE];
  logic [PTR_W-1:0]  top_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;

  assign top_ptr = sel_ptr - PTR_W'(1);
  assign wr_en   = (op == OP_PUSH) || (op == OP_SWAP);
  assign wr_ptr  = (op == OP_SWAP) ? top_ptr : sel_ptr;
  assign wr_addr = {ch_sel, wr_ptr};
  assign rd_addr = {ch_sel, top_ptr};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= data_in;
    end
  end

  // --------------------------------------------------------------------------
  // Output register. On a swap the read and the write hit the same address;
  // the read returns the old top (read-before-write).
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] data_out_reg;
  logic             out_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (op)
        OP_POP, OP_SWAP: begin
          data_out_reg  <= mem[rd_addr];
          out_valid_reg <= 1'b1;
        end
        OP_PASS: begin
          data_out_reg  <= data_in;
          out_valid_reg <= 1'b1;
        end
        default: data_out_reg <= data_out_reg;
      endcase
    end
  end

  assign data_out  = data_out_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_lifo_multi.sv
// ----------------------------------------------------------------------------
// tb_lifo_multi
//  Self-checking bench for lifo_multi with default parameters. A stack model
//  per channel predicts popped words, which are queued when the operation is
//  driven and compared when the DUT pulses out_valid. Status outputs are
//  compared against the model after every operation.
// ----------------------------------------------------------------------------
module tb_lifo_multi;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 5;

`ifdef LIFO_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [CH_W-1:0]         ch_sel;
  logic                    push, pop, flush, err_clr;
  logic [WIDTH-1:0]        data_in;
  logic [WIDTH-1:0]        data_out;
  logic                    out_valid;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       empty, full, overflow, underflow;

  lifo_multi #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_sel    (ch_sel),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .data_in   (data_in),
    .data_out  (data_out),
    .out_valid (out_valid),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .err_clr   (err_clr),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0]  model [NUM_CH][$];
  logic [NUM_CH-1:0] ovf_m;
  logic [NUM_CH-1:0] unf_m;
  logic [WIDTH-1:0]  exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    logic [NUM_CH*CNT_W-1:0] c;
    logic [NUM_CH-1:0]       e;
    logic [NUM_CH-1:0]       f;
    for (int k = 0; k < NUM_CH; k++) begin
      c[k*CNT_W +: CNT_W] = CNT_W'(model[k].size());
      e[k] = (model[k].size() == 0);
      f[k] = (model[k].size() == DEPTH);
    end
    check({tag, " count"}, 64'(count), 64'(c));
    check({tag, " empty"}, 64'(empty), 64'(e));
    check({tag, " full"}, 64'(full), 64'(f));
    check({tag, " overflow"}, 64'(overflow), 64'(ovf_m));
    check({tag, " underflow"}, 64'(underflow), 64'(unf_m));
  endtask

  // One operation: drive on the falling edge, update the model, sample 1 ns
  // after the rising edge that consumes it.
  task automatic do_op(input int ch, input bit pu, input bit po, input bit fl,
                       input bit clr, input logic [WIDTH-1:0] d);
    bit exp_v;
    exp_v = 1'b0;
    @(negedge clk);
    ch_sel  = ch[CH_W-1:0];
    push    = pu;
    pop     = po;
    flush   = fl;
    err_clr = clr;
    data_in = d;
    if (clr && FLAGS) begin
      ovf_m = '0;
      unf_m = '0;
    end
    if (fl) begin
      model[ch].delete();
    end else if (pu && po) begin
      exp_v = 1'b1;
      if (model[ch].size() > 0) begin
        exp_q.push_back(model[ch].pop_back());
        model[ch].push_back(d);
      end else begin
        exp_q.push_back(d);
      end
    end else if (pu) begin
      if (model[ch].size() < DEPTH) model[ch].push_back(d);
      else if (FLAGS) ovf_m[ch] = 1'b1;
    end else if (po) begin
      if (model[ch].size() > 0) begin
        exp_v = 1'b1;
        exp_q.push_back(model[ch].pop_back());
      end else if (FLAGS) begin
        unf_m[ch] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    $display("op ch=%0d push=%0b pop=%0b flush=%0b clr=%0b din=0x%0h -> out_valid=%0b data_out=0x%0h count=0x%0h",
             ch, pu, po, fl, clr, d, out_valid, data_out, count);
    check("out_valid", 64'(out_valid), 64'(exp_v));
    if (exp_v && exp_q.size() > 0) check("data_out", 64'(data_out), 64'(exp_q.pop_front()));
    check_status("status");
    push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ch_sel = '0; push = 1'b0; pop = 1'b0; flush = 1'b0;
    err_clr = 1'b0; data_in = '0; ovf_m = '0; unf_m = '0;

    // Reset state
    #1;
    check("reset count", 64'(count), 64'd0);
    check("reset empty", 64'(empty), 64'hF);
    check("reset full", 64'(full), 64'd0);
    check("reset data_out", 64'(data_out), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset flags", 64'({overflow, underflow}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: LIFO order on ch0
    do_op(0, 1, 0, 0, 0, 32'hA);
    do_op(0, 1, 0, 0, 0, 32'hB);
    do_op(0, 1, 0, 0, 0, 32'hC);
    do_op(0, 0, 1, 0, 0, 0);
    check("t1 first pop", 64'(data_out), 64'hC);
    do_op(0, 0, 1, 0, 0, 0);
    do_op(0, 0, 1, 0, 0, 0);
    check("t1 last pop", 64'(data_out), 64'hA);
    check("t1 empty0", 64'(empty[0]), 64'd1);

    // 2: fill ch1, overflow, pop top
    for (int i = 0; i < DEPTH; i++) do_op(1, 1, 0, 0, 0, 32'h11 + 32'(i));
    check("t2 full1", 64'(full[1]), 64'd1);
    check("t2 count1", 64'(count[1*CNT_W +: CNT_W]), 64'd16);
    do_op(1, 1, 0, 0, 0, 32'hFF);
    check("t2 overflow1", 64'(overflow[1]), 64'(FLAGS));
    check("t2 count1 held", 64'(count[1*CNT_W +: CNT_W]), 64'd16);
    do_op(1, 0, 1, 0, 0, 0);
    check("t2 pop after drop", 64'(data_out), 64'h20);

    // 3: interleaved channels
    do_op(2, 1, 0, 0, 0, 32'h1);
    do_op(3, 1, 0, 0, 0, 32'h2);
    do_op(2, 1, 0, 0, 0, 32'h3);
    do_op(3, 0, 1, 0, 0, 0);
    do_op(2, 0, 1, 0, 0, 0);
    check("t3 ch2 top", 64'(data_out), 64'h3);
    do_op(2, 0, 1, 0, 0, 0);
    check("t3 count1 untouched", 64'(count[1*CNT_W +: CNT_W]), 64'd15);

    // 4: swap and pass-through
    do_op(0, 1, 0, 0, 0, 32'h5);
    do_op(0, 1, 1, 0, 0, 32'h9);
    check("t4 swap out", 64'(data_out), 64'h5);
    check("t4 swap count", 64'(count[0 +: CNT_W]), 64'd1);
    do_op(0, 0, 1, 0, 0, 0);
    check("t4 swapped in", 64'(data_out), 64'h9);
    do_op(0, 1, 1, 0, 0, 32'h7);
    check("t4 pass out", 64'(data_out), 64'h7);
    // swap on a full stack is legal and raises no flag
    do_op(1, 1, 0, 0, 0, 32'h55);
    do_op(1, 1, 1, 0, 0, 32'h66);
    check("t4 full swap out", 64'(data_out), 64'h55);

    // 5: flush wins over push, underflow and clear
    do_op(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) do_op(1, 1, 0, 0, 0, 32'h30 + 32'(i));
    do_op(1, 1, 0, 1, 0, 32'hEE);
    check("t5 flush count", 64'(count[1*CNT_W +: CNT_W]), 64'd0);
    do_op(1, 0, 1, 0, 0, 0);
    check("t5 underflow1", 64'(underflow[1]), 64'(FLAGS));
    do_op(1, 0, 0, 0, 1, 0);
    check("t5 cleared", 64'(underflow[1]), 64'd0);
    do_op(1, 1, 0, 0, 0, 32'h44);
    do_op(1, 0, 1, 0, 0, 0);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) do_op(0, 1, 0, 0, 0, 32'h80 + 32'(i));
    do_op(0, 0, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset asserted -> out_valid=%0b data_out=0x%0h count=0x%0h empty=0x%0h",
             out_valid, data_out, count, empty);
    check("t6 count", 64'(count), 64'd0);
    check("t6 empty", 64'(empty), 64'hF);
    check("t6 data_out", 64'(data_out), 64'd0);
    check("t6 out_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < NUM_CH; k++) model[k].delete();
    ovf_m = '0; unf_m = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 1, 0, 0, 0, 32'h77);
    do_op(0, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
